// File: rtl/inst_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: RV opcodes, immediate-format
// codes (also consumed by the immediate generator) and the queue entry layout.
package inst_fetch_queue_pkg;

  localparam logic [2:0] IMM_I    = 3'd0;
  localparam logic [2:0] IMM_S    = 3'd1;
  localparam logic [2:0] IMM_SB   = 3'd2;
  localparam logic [2:0] IMM_NONE = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_UJ   = 3'd5;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [2:0]  imm_sel;
    logic        illegal;
  } fq_entry_t;

  // Anything that is not a 32-bit encoding (low bits != 2'b11) is flagged.
  function automatic logic is_illegal(input logic [31:0] inst);
    return (inst[1:0] != 2'b11);
  endfunction

endpackage

// File: rtl/inst_fetch_queue_imm_sel_decode.sv
// Opcode to immediate-format decoder; purely combinational.
module imm_sel_decode
  import inst_fetch_queue_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic       unused_tie,
  output logic [2:0] imm_sel
);

  // Map the major opcode onto the immediate-format code.
  always_comb begin
    imm_sel = IMM_NONE;
    case (opcode)
      OP_IMM, OP_LOAD, OP_IMM_32, OP_JALR: imm_sel = IMM_I;
      OP_STORE:                           imm_sel = IMM_S;
      OP_BRANCH:                          imm_sel = IMM_SB;
      OP_LUI, OP_AUIPC:                   imm_sel = IMM_U;
      OP_JAL:                             imm_sel = IMM_UJ;
      default:                            imm_sel = IMM_NONE;
    endcase
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Two-entry fetch-to-decode queue; immediate format and legality are resolved
// at enqueue so decode sees them straight from registers.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [63:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [63:0] out_pc,
  output logic [2:0]  out_imm_sel,
  output logic        out_illegal
);

  fq_entry_t  mem_r [2];
  logic       wr_ptr_r;
  logic       rd_ptr_r;
  logic [1:0] count_r;

  logic       enq_s;
  logic       deq_s;
  logic [2:0] imm_sel_s;
  fq_entry_t  new_entry_s;

  imm_sel_decode u_imm_sel_decode (
    .opcode     (in_inst[6:0]),
    .unused_tie (1'b0),
    .imm_sel    (imm_sel_s)
  );

  assign in_ready    = (count_r < 2'd2);
  assign out_valid   = (count_r != 2'd0);
  assign out_inst    = mem_r[rd_ptr_r].inst;
  assign out_pc      = mem_r[rd_ptr_r].pc;
  assign out_imm_sel = mem_r[rd_ptr_r].imm_sel;
  assign out_illegal = mem_r[rd_ptr_r].illegal;

  // Handshake qualification and the entry to be written.
  always_comb begin
    enq_s               = in_valid && in_ready && !flush;
    deq_s               = out_valid && out_ready && !flush;
    new_entry_s.inst    = in_inst;
    new_entry_s.pc      = in_pc;
    new_entry_s.imm_sel = imm_sel_s;
    new_entry_s.illegal = is_illegal(in_inst);
  end

  // Queue storage, pointers and occupancy; reset beats flush beats handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_r[i].inst    <= 32'h0;
        mem_r[i].pc      <= 64'h0;
        mem_r[i].imm_sel <= IMM_NONE;
        mem_r[i].illegal <= 1'b0;
      end
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else if (flush) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (enq_s) begin
        mem_r[wr_ptr_r] <= new_entry_s;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (deq_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: fetch unit presents an instruction.
REQ-004 SHALL have port in_ready, output, 1 bit: queue accepts the instruction this cycle.
REQ-005 SHALL have port in_inst, input, 32 bits: raw RV instruction word.
REQ-006 SHALL have port in_pc, input, 64 bits: PC of in_inst.
REQ-007 SHALL have port flush, input, 1 bit: discard all queued and incoming instructions (branch redirect).
REQ-008 SHALL have port out_valid, output, 1 bit: head entry valid toward decode.
REQ-009 SHALL have port out_ready, input, 1 bit: decode consumes the head entry.
REQ-010 SHALL have port out_inst, output, 32 bits: head instruction.
REQ-011 SHALL have port out_pc, output, 64 bits: head PC.
REQ-012 SHALL have port out_imm_sel, output, 3 bits: immediate-format select for the immediate generator.
REQ-013 SHALL have port out_illegal, output, 1 bit: head instruction has inst[1:0] != 2'b11.

Function
REQ-014 SHALL be a 2-entry FIFO; entry = {inst, pc, imm_sel, illegal}.
REQ-015 Enqueue SHALL occur on an edge where in_valid && in_ready && !flush.
REQ-016 Dequeue SHALL occur on an edge where out_valid && out_ready && !flush.
REQ-017 in_ready SHALL be (count < 2), from registered state only, with no combinational path from out_ready.
REQ-018 out_valid SHALL be (count != 0); out_inst/out_pc/out_imm_sel/out_illegal SHALL come from the head entry registers, with no combinational path from in_*.
REQ-019 Latency: an entry enqueued into an empty queue at edge N SHALL appear with out_valid=1 after edge N; no same-cycle bypass.
REQ-020 Throughput SHALL be 1 instr/cycle sustained when count=1 and both handshakes fire: count stays 1 and the new entry becomes head after the edge.
REQ-021 When full, in_ready=0; a dequeue at that edge SHALL yield count=1, with in_ready=1 in the following cycle.
REQ-022 When empty, out_ready SHALL have no effect.
REQ-023 Read/write pointers are 1 bit each and SHALL wrap modulo 2; count is 2 bits, range 0..2.
REQ-024 flush SHALL set count=0 at the next edge and drop any same-cycle enqueue/dequeue; flush has priority over both.
REQ-025 imm_sel SHALL be decoded from inst[6:0] at enqueue time and stored: 0010011/0000011/0011011/1100111 -> 3'd0 (I); 0100011 -> 3'd1 (S); 1100011 -> 3'd2 (SB); 0110111/0010111 -> 3'd4 (U); 1101111 -> 3'd5 (UJ); all others -> 3'd3 (no immediate).
REQ-026 Codes 3'd6 and 3'd7 SHALL never be produced.
REQ-027 illegal SHALL be stored at enqueue as (inst[1:0] != 2'b11); the instruction is still queued normally.

Reset
REQ-028 While rst=1 at an edge, count and both pointers SHALL become 0, so out_valid=0 and in_ready=1 after the edge.
REQ-029 Reset SHALL clear both entries: out_inst=32'h0, out_pc=64'h0, out_imm_sel=3'd3, out_illegal=0.
REQ-030 Reset SHALL override flush and both handshakes; a reset asserted mid-stream SHALL discard all entries.

Structure
REQ-031 Opcode constants and imm_sel codes (IMM_I=0, IMM_S=1, IMM_SB=2, IMM_NONE=3, IMM_U=4, IMM_UJ=5) SHALL live in the shared package so the immediate generator uses identical codes.
REQ-032 The opcode-to-imm_sel mapping SHALL be one combinational sub-module, imm_sel_decode (in: opcode[6:0]; out: imm_sel[2:0]).

Verification
REQ-033 Reset, then enqueue inst=32'h00500093 (addi), pc=64'h1000 -> next cycle out_valid=1, out_imm_sel=0, out_pc=64'h1000, out_illegal=0.
REQ-034 out_ready=0; push 32'h00112023 (sw), then 32'hFE000EE3 (beq) -> in_ready=0 after the 2nd push; head imm_sel=1; after one dequeue, head imm_sel=2 and in_ready=1.
REQ-035 count=1, in_valid=1 and out_ready=1 for 8 cycles with lui/auipc/jal/add -> one instruction out per cycle in order; imm_sel 4,4,5,3 repeating.
REQ-036 Full queue, then flush=1 with in_valid=1 and out_ready=1 -> next cycle out_valid=0, in_ready=1, and the flushed-cycle input never appears.
REQ-037 Enqueue 32'h00000000 -> out_illegal=1, out_imm_sel=3.
REQ-038 rst=1 asserted with 2 entries held -> next cycle out_valid=0, out_inst=0, out_imm_sel=3.
